// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and control-bundle type for pipe_stall_ctrl.
package pipe_stall_ctrl_pkg;

  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LHB = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    PS_RUN      = 3'd0,
    PS_LU_MASK  = 3'd1,
    PS_FLUSH    = 3'd2,
    PS_MEM_WAIT = 3'd3,
    PS_DRAIN    = 3'd4,
    PS_HALT     = 3'd5
  } ps_state_e;

  typedef struct packed {
    logic pc_we;
    logic pc_sel;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_we;
    logic memwb_we;
    logic halted;
  } ps_ctrl_t;

  localparam ps_ctrl_t CTRL_DEFAULT = '{pc_we: 1'b1, pc_sel: 1'b0, ifid_we: 1'b1,
                                        ifid_flush: 1'b0, idex_bubble: 1'b0,
                                        exmem_we: 1'b1, memwb_we: 1'b1, halted: 1'b0};

endpackage

// File: rtl/pipe_stall_ctrl_down_cnt.sv
// Loadable down-counter with hold; used for both the flush and drain countdowns.
module pipe_down_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!hold) begin
      if (load)
        cnt <= load_val;
      else if (dec && cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush/halt sequencer with Mealy control outputs.
// Optional stall_cycles counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard,
  input  logic        br_taken,
  input  logic [3:0]  id_opcode,
  input  logic        mem_busy,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_we,
  output logic        memwb_we,
`ifdef PIPE_STALL_CNT_EN
  output logic [15:0] stall_cycles,
`endif
  output logic        halted
);

  ps_state_e  state, ret_state, eff_state, nxt_state, nxt_ret;
  ps_ctrl_t   ctrl;
  logic       cnt_hold, f_load, f_dec, d_load, d_dec;
  logic [2:0] flush_cnt, drain_cnt;

  // A MEM_WAIT cycle with mem_busy low behaves exactly like a cycle of the preempted state.
  always_comb begin
    eff_state = (state == PS_MEM_WAIT) ? ret_state : state;
    ctrl      = CTRL_DEFAULT;
    nxt_state = eff_state;
    nxt_ret   = ret_state;
    cnt_hold  = 1'b0;
    f_load    = 1'b0;
    f_dec     = 1'b0;
    d_load    = 1'b0;
    d_dec     = 1'b0;
    if (eff_state == PS_HALT) begin
      ctrl = '{pc_we: 1'b0, pc_sel: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
               idex_bubble: 1'b1, exmem_we: 1'b0, memwb_we: 1'b0, halted: 1'b1};
    end else if (mem_busy) begin
      ctrl      = '0;
      nxt_state = PS_MEM_WAIT;
      nxt_ret   = eff_state;
      cnt_hold  = 1'b1;
    end else begin
      case (eff_state)
        PS_RUN, PS_LU_MASK: begin
          nxt_state = PS_RUN;
          if (br_taken) begin
            ctrl.pc_sel      = 1'b1;
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              nxt_state = PS_FLUSH;
              f_load    = 1'b1;
            end
          end else if (id_opcode == OP_HLT) begin
            ctrl.pc_we      = 1'b0;
            ctrl.ifid_flush = 1'b1;
            nxt_state       = PS_DRAIN;
            d_load          = 1'b1;
          end else if (hazard && eff_state == PS_RUN) begin
            ctrl.pc_we       = 1'b0;
            ctrl.ifid_we     = 1'b0;
            ctrl.idex_bubble = 1'b1;
            nxt_state        = PS_LU_MASK;
          end
        end
        PS_FLUSH: begin
          ctrl.ifid_flush = 1'b1;
          f_dec           = 1'b1;
          if (flush_cnt == 3'd1) nxt_state = PS_RUN;
        end
        PS_DRAIN: begin
          ctrl.pc_we       = 1'b0;
          ctrl.ifid_flush  = 1'b1;
          ctrl.idex_bubble = 1'b1;
          d_dec            = 1'b1;
          if (drain_cnt == 3'd1) nxt_state = PS_HALT;
        end
        default: nxt_state = PS_RUN;
      endcase
    end
    if (rst) begin
      ctrl = '{pc_we: 1'b0, pc_sel: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1,
               idex_bubble: 1'b1, exmem_we: 1'b0, memwb_we: 1'b0, halted: 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PS_RUN;
      ret_state <= PS_RUN;
    end else begin
      state     <= nxt_state;
      ret_state <= nxt_ret;
    end
  end

  pipe_down_cnt #(.W(3)) u_flush_cnt (
    .clk(clk), .rst(rst), .hold(cnt_hold), .load(f_load),
    .load_val(3'(FLUSH_CYCLES - 1)), .dec(f_dec), .cnt(flush_cnt)
  );

  pipe_down_cnt #(.W(3)) u_drain_cnt (
    .clk(clk), .rst(rst), .hold(cnt_hold), .load(d_load),
    .load_val(3'(DRAIN_CYCLES)), .dec(d_dec), .cnt(drain_cnt)
  );

`ifdef PIPE_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (state != PS_HALT && !ctrl.pc_we && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

  assign pc_we       = ctrl.pc_we;
  assign pc_sel      = ctrl.pc_sel;
  assign ifid_we     = ctrl.ifid_we;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;
  assign exmem_we    = ctrl.exmem_we;
  assign memwb_we    = ctrl.memwb_we;
  assign halted      = ctrl.halted;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Random-stimulus bench for pipe_stall_ctrl against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;
  import pipe_stall_ctrl_pkg::*;

  localparam int FC = 3;
  localparam int DC = 3;
  localparam int N_CYC = 4000;

  logic       clk = 1'b0;
  logic       rst, hazard, br_taken, mem_busy;
  logic [3:0] id_opcode;
  logic       pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we, halted;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  pipe_stall_ctrl #(.FLUSH_CYCLES(FC), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .hazard(hazard), .br_taken(br_taken),
    .id_opcode(id_opcode), .mem_busy(mem_busy),
    .pc_we(pc_we), .pc_sel(pc_sel), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_we(exmem_we), .memwb_we(memwb_we),
`ifdef PIPE_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: remaining flush/drain cycles, whether hazard is masked this cycle, and halt.
  // A mem_busy cycle is simply a frozen cycle: nothing advances.
  int  flush_left = 0;
  int  drain_left = 0;
  bit  masked = 0;
  bit  halt_m = 0;
  int  stalls = 0;

  initial begin
    bit e_pcwe, e_sel, e_ifwe, e_fl, e_bub, e_exwe, e_mwwe, e_halt;
    rst = 1'b1; hazard = 1'b0; br_taken = 1'b0; mem_busy = 1'b0; id_opcode = 4'h0;
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk);
      #1;
      rst       = (cyc < 2) || ($urandom_range(0, 99) < 2);
      hazard    = $urandom_range(0, 99) < 35;
      br_taken  = $urandom_range(0, 99) < 10;
      mem_busy  = $urandom_range(0, 99) < 15;
      id_opcode = ($urandom_range(0, 99) < 4) ? OP_HLT : 4'($urandom_range(0, 14));
      #3;
      {e_pcwe, e_sel, e_ifwe, e_fl, e_bub, e_exwe, e_mwwe, e_halt} = 8'b1010_0110;
      if (rst) begin
        {e_pcwe, e_sel, e_ifwe, e_fl, e_bub, e_exwe, e_mwwe, e_halt} = 8'b0001_1000;
      end else if (halt_m) begin
        {e_pcwe, e_sel, e_ifwe, e_fl, e_bub, e_exwe, e_mwwe, e_halt} = 8'b0000_1001;
      end else if (mem_busy) begin
        {e_pcwe, e_sel, e_ifwe, e_fl, e_bub, e_exwe, e_mwwe, e_halt} = 8'b0;
      end else if (drain_left > 0) begin
        e_pcwe = 0; e_fl = 1; e_bub = 1;
      end else if (flush_left > 0) begin
        e_fl = 1;
      end else if (br_taken) begin
        e_sel = 1; e_fl = 1; e_bub = 1;
      end else if (id_opcode == OP_HLT) begin
        e_pcwe = 0; e_fl = 1;
      end else if (hazard && !masked) begin
        e_pcwe = 0; e_ifwe = 0; e_bub = 1;
      end

      check($sformatf("ctrl@%0d", cyc),
            {24'b0, pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we, halted},
            {24'b0, e_pcwe, e_sel, e_ifwe, e_fl, e_bub, e_exwe, e_mwwe, e_halt});
`ifdef PIPE_STALL_CNT_EN
      if (cyc > 0) check($sformatf("stall_cycles@%0d", cyc), {16'b0, stall_cycles}, 32'(stalls));
`endif

      if (rst) begin
        stalls = 0;
      end else if (!halt_m && !e_pcwe && stalls < 65535) begin
        stalls++;
      end

      if (rst) begin
        flush_left = 0; drain_left = 0; masked = 0; halt_m = 0;
      end else if (halt_m || mem_busy) begin
        // frozen
      end else if (drain_left > 0) begin
        drain_left--;
        if (drain_left == 0) halt_m = 1;
      end else if (flush_left > 0) begin
        flush_left--;
      end else if (br_taken) begin
        flush_left = FC - 1; masked = 0;
      end else if (id_opcode == OP_HLT) begin
        drain_left = DC; masked = 0;
      end else if (hazard && !masked) begin
        masked = 1;
      end else begin
        masked = 0;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
